// File: rtl/mult_div_seq.sv
// Multicycle signed multiply (radix-2 Booth) / signed restoring divide
// sequencer that feeds the HI/LO registers; WIDTH+1 cycles per operation.
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             hilo_write,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN, S_ERR} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_op;
  logic             r_sa;
  logic             r_sb;
  logic [WIDTH-1:0] r_mc;   // MULT: multiplicand; DIV: |divisor|
  logic [WIDTH:0]   r_ph;   // MULT: P_hi (one guard bit); DIV: partial remainder
  logic [WIDTH-1:0] r_pl;   // MULT: P_lo (multiplier); DIV: dividend -> quotient
  logic             r_qm1;
  logic             r_busy;
  logic             r_done;
  logic             r_hilo_write;
  logic             r_div0;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_mext;
  logic [WIDTH:0]   w_bsum;
  logic [WIDTH:0]   w_rsh;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_nph;
  logic [WIDTH-1:0] w_npl;
  logic             w_nqm1;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;
  logic             w_last;

  assign w_a_mag = a[WIDTH-1] ? -a : a;
  assign w_b_mag = b[WIDTH-1] ? -b : b;
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  // The guard bit on P_hi keeps Booth exact for the most negative multiplicand.
  always_comb begin
    w_mext  = {r_mc[WIDTH-1], r_mc};
    w_bsum  = r_ph;
    w_rsh   = {r_ph[WIDTH-1:0], r_pl[WIDTH-1]};
    w_trial = w_rsh - {1'b0, r_mc};
    w_nph   = r_ph;
    w_npl   = r_pl;
    w_nqm1  = r_qm1;
    case ({r_pl[0], r_qm1})
      2'b01:   w_bsum = r_ph + w_mext;
      2'b10:   w_bsum = r_ph - w_mext;
      default: w_bsum = r_ph;
    endcase
    if (!r_op) begin
      w_nph  = {w_bsum[WIDTH], w_bsum[WIDTH:1]};
      w_npl  = {w_bsum[0], r_pl[WIDTH-1:1]};
      w_nqm1 = r_pl[0];
    end else if (!w_trial[WIDTH]) begin
      w_nph = w_trial;
      w_npl = {r_pl[WIDTH-2:0], 1'b1};
    end else begin
      w_nph = w_rsh;
      w_npl = {r_pl[WIDTH-2:0], 1'b0};
    end
    w_res_hi = w_nph[WIDTH-1:0];
    w_res_lo = w_npl;
    if (r_op) begin
      w_res_lo = (r_sa ^ r_sb) ? -w_npl : w_npl;
      w_res_hi = r_sa ? -w_nph[WIDTH-1:0] : w_nph[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_op         <= 1'b0;
      r_sa         <= 1'b0;
      r_sb         <= 1'b0;
      r_mc         <= '0;
      r_ph         <= '0;
      r_pl         <= '0;
      r_qm1        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_hilo_write <= 1'b0;
      r_div0       <= 1'b0;
      r_hi         <= '0;
      r_lo         <= '0;
    end else begin
      r_done       <= 1'b0;
      r_hilo_write <= 1'b0;
      r_div0       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && op && (b == '0)) begin
            r_state <= S_ERR;
            r_busy  <= 1'b1;
            r_done  <= 1'b1;
            r_div0  <= 1'b1;
          end else if (start) begin
            r_state <= S_CALC;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_op    <= op;
            r_ph    <= '0;
            r_qm1   <= 1'b0;
            r_sa    <= a[WIDTH-1];
            r_sb    <= b[WIDTH-1];
            r_mc    <= op ? w_b_mag : a;
            r_pl    <= op ? w_a_mag : b;
          end
        end
        S_CALC: begin
          r_ph  <= w_nph;
          r_pl  <= w_npl;
          r_qm1 <= w_nqm1;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state      <= S_FIN;
            r_hi         <= w_res_hi;
            r_lo         <= w_res_lo;
            r_done       <= 1'b1;
            r_hilo_write <= 1'b1;
          end
        end
        S_FIN, S_ERR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign hilo_write = r_hilo_write;
  assign div0       = r_div0;
  assign hi         = r_hi;
  assign lo         = r_lo;

endmodule
